// File: rtl/ysyx_22040729_ifu_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040729_ifu_if
// Description : Fetch-unit bus bundle: imem request/response, redirect, decode.
// Revision    : 1.0
// ============================================================================
interface ysyx_22040729_ifu_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_resp_valid;
    logic [63:0]           imem_resp_data;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, inst_ready
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22040729_ifu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040729_ifu
// Description : Single-outstanding instruction fetch with small decode FIFO.
// Revision    : 1.0
// ============================================================================
module ysyx_22040729_ifu #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(64'h8000_0000),
    parameter int                    FIFO_DEPTH = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    ysyx_22040729_ifu_if.master bus
);
    localparam int                    c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                    c_CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W-1:0]    c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0]    c_LAST_PTR = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_RESET_PC = {RESET_ADDR[ADDR_WIDTH-1:2], 2'b00};

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_issued_pc;
    logic [ADDR_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [INST_WIDTH-1:0] r_fifo_inst [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_req_valid;
    logic                  w_req_fire;
    logic                  w_inst_valid;
    logic                  w_push;
    logic                  w_pop;
    logic [INST_WIDTH-1:0] w_sel;
    logic [ADDR_WIDTH-1:0] w_redirect_pc;
    logic [c_PTR_W-1:0]    w_rd_ptr_nxt;
    logic [c_PTR_W-1:0]    w_wr_ptr_nxt;
    logic                  w_unused_pc_lsb;

    assign w_req_valid  = !rst && (r_state == ST_REQ) && (r_count < c_DEPTH);
    assign w_req_fire   = w_req_valid && bus.imem_req_ready;
    assign w_inst_valid = !rst && (r_count != '0);
    // A redirect squashes whatever would have moved through the FIFO this cycle.
    assign w_push       = !rst && (r_state == ST_WAIT) && bus.imem_resp_valid && !bus.redirect_valid;
    assign w_pop        = w_inst_valid && bus.inst_ready && !bus.redirect_valid;
    assign w_sel        = r_issued_pc[2] ? bus.imem_resp_data[63:32] : bus.imem_resp_data[31:0];

    assign w_redirect_pc   = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign w_unused_pc_lsb = ^bus.redirect_pc[1:0];

    assign w_rd_ptr_nxt = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);
    assign w_wr_ptr_nxt = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.inst_valid     = w_inst_valid;
    assign bus.inst           = rst ? '0 : r_fifo_inst[r_rd_ptr];
    assign bus.inst_pc        = rst ? '0 : r_fifo_pc[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_REQ;
            r_fetch_pc  <= c_RESET_PC;
            r_issued_pc <= '0;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
        end else begin
            if (w_req_fire) begin
                r_issued_pc <= r_fetch_pc;
            end
            if (bus.redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                // Any request already in flight (or accepted now) returns wrong-path data.
                case (r_state)
                    ST_REQ:  r_state <= w_req_fire ? ST_DROP : ST_REQ;
                    ST_WAIT,
                    ST_DROP: r_state <= bus.imem_resp_valid ? ST_REQ : ST_DROP;
                    default: r_state <= ST_REQ;
                endcase
            end else begin
                if (w_push) begin
                    r_wr_ptr <= w_wr_ptr_nxt;
                end
                if (w_pop) begin
                    r_rd_ptr <= w_rd_ptr_nxt;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
                case (r_state)
                    ST_REQ: begin
                        if (w_req_fire) begin
                            r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
                            r_state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT,
                    ST_DROP: begin
                        if (bus.imem_resp_valid) begin
                            r_state <= ST_REQ;
                        end
                    end
                    default: r_state <= ST_REQ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_issued_pc;
            r_fifo_inst[r_wr_ptr] <= w_sel;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040729_ifu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22040729_ifu
// Description : Scoreboard bench with a single-outstanding memory model.
// Revision    : 1.0
// ============================================================================
module tb_ysyx_22040729_ifu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_22040729_ifu_if #(.ADDR_WIDTH(64), .INST_WIDTH(32)) bus ();

    ysyx_22040729_ifu #(
        .ADDR_WIDTH(64),
        .INST_WIDTH(32),
        .RESET_ADDR(64'h8000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          m_pend  = 0;
    bit          m_stale = 0;
    int          m_left  = 0;
    int          m_delay = 1;
    logic [63:0] m_addr  = '0;
    logic [63:0] m_fetch = 64'h8000_0000;

    function automatic logic [63:0] mem_dword(input logic [63:0] a);
        logic [63:0] b;
        b = {a[63:3], 3'b000};
        if (b == 64'h8000_0000) return 64'h00500093_00000013;
        return {(b[31:0] + 32'd4) ^ 32'h5EED_C0DE, b[31:0] ^ 32'h5EED_C0DE};
    endfunction

    // One clock: account for handshakes seen this cycle, advance, drive memory.
    task automatic tick();
        logic        fire;
        logic [63:0] d;
        exp_t        e;
        fire = bus.imem_req_valid && bus.imem_req_ready;
        if (!rst) begin
            if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_pop: got pc=%h inst=%h, expected no instruction", bus.inst_pc, bus.inst);
                end else begin
                    e = q.pop_front();
                    if (bus.inst_pc !== e.pc || bus.inst !== e.inst) begin
                        n_fail++;
                        $display("FAIL sb_inst: got pc=%h inst=%h, expected pc=%h inst=%h", bus.inst_pc, bus.inst, e.pc, e.inst);
                    end
                end
            end
            if (bus.imem_resp_valid) begin
                if (m_pend && !m_stale && !bus.redirect_valid) begin
                    d      = mem_dword(m_addr);
                    e.pc   = m_addr;
                    e.inst = m_addr[2] ? d[63:32] : d[31:0];
                    q.push_back(e);
                end
                m_pend = 0;
            end
            if (bus.redirect_valid) begin
                q.delete();
                if (m_pend) m_stale = 1;
            end
            if (fire) begin
                n_cmp++;
                if (m_pend || bus.imem_req_addr !== m_fetch) begin
                    n_fail++;
                    $display("FAIL req_addr: got %h (outstanding=%0d), expected %h with none outstanding", bus.imem_req_addr, m_pend, m_fetch);
                end
                m_pend  = 1;
                m_stale = bus.redirect_valid;
                m_addr  = m_fetch;
                m_left  = m_delay;
                m_fetch = m_fetch + 64'd4;
            end
            if (bus.redirect_valid) m_fetch = {bus.redirect_pc[63:2], 2'b00};
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_pend  = 0;
            m_stale = 0;
            m_fetch = 64'h8000_0000;
            q.delete();
        end
        if (m_pend) begin
            m_left--;
            bus.imem_resp_valid = (m_left == 0);
            bus.imem_resp_data  = mem_dword(m_addr);
        end else begin
            bus.imem_resp_valid = 1'b0;
        end
        n_cmp++;
        if (bus.inst_valid !== (!rst && q.size() != 0)) begin
            n_fail++;
            $display("FAIL inst_valid: got %b, expected %b", bus.inst_valid, (!rst && q.size() != 0));
        end
        n_cmp++;
        if (bus.imem_req_valid !== (!rst && !m_pend && q.size() < 2)) begin
            n_fail++;
            $display("FAIL req_valid: got %b, expected %b", bus.imem_req_valid, (!rst && !m_pend && q.size() < 2));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.redirect_valid  = 1'b0;
        m_delay = 1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b expected 0", bus.imem_req_valid); end
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b expected 0", bus.inst_valid); end
        n_cmp++; if (bus.inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h expected 0", bus.inst); end
        n_cmp++; if (bus.inst_pc !== 64'h0) begin n_fail++; $display("FAIL rst_inst_pc: got %h expected 0", bus.inst_pc); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %b expected 1", bus.imem_req_valid); end
        n_cmp++; if (bus.imem_req_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL first_req_addr: got %h expected 80000000", bus.imem_req_addr); end
    endtask

    task automatic test_basic();
        tick();
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n1: got inst_valid=%b expected 0", bus.inst_valid); end
        tick();
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h0000_0013 || bus.inst_pc !== 64'h8000_0000) begin
            n_fail++; $display("FAIL first_inst: got v=%b inst=%h pc=%h expected 1/00000013/80000000", bus.inst_valid, bus.inst, bus.inst_pc); end
        n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h8000_0004) begin
            n_fail++; $display("FAIL second_req: got v=%b addr=%h expected 1/80000004", bus.imem_req_valid, bus.imem_req_addr); end
        repeat (2) tick();
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h0050_0093 || bus.inst_pc !== 64'h8000_0004) begin
            n_fail++; $display("FAIL hi_word: got v=%b inst=%h pc=%h expected 1/00500093/80000004", bus.inst_valid, bus.inst, bus.inst_pc); end
        repeat (20) tick();
    endtask

    task automatic test_backpressure();
        bus.inst_ready = 1'b0;
        do_reset();
        repeat (8) tick();
        n_cmp++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_full: got req_valid=%b inst_valid=%b expected 0/1", bus.imem_req_valid, bus.inst_valid); end
        repeat (3) tick();
        n_cmp++; if (bus.inst !== 32'h0000_0013 || bus.inst_pc !== 64'h8000_0000) begin
            n_fail++; $display("FAIL bp_stable: got inst=%h pc=%h expected 00000013/80000000", bus.inst, bus.inst_pc); end
        bus.inst_ready = 1'b1;
        tick();
        n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h8000_0008) begin
            n_fail++; $display("FAIL bp_resume: got v=%b addr=%h expected 1/80000008", bus.imem_req_valid, bus.imem_req_addr); end
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'h8000_0004) begin
            n_fail++; $display("FAIL bp_second: got v=%b pc=%h expected 1/80000004", bus.inst_valid, bus.inst_pc); end
        tick();
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL bp_depth: got inst_valid=%b expected 0", bus.inst_valid); end
        repeat (10) tick();
    endtask

    task automatic test_redirect_wait();
        do_reset();
        m_delay = 3;
        tick();
        redirect_to(64'h8000_0100);
        n_cmp++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rw_drop: got inst_valid=%b req_valid=%b expected 0/0", bus.inst_valid, bus.imem_req_valid); end
        tick();
        tick();
        n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h8000_0100 || bus.inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL rw_req: got v=%b addr=%h iv=%b expected 1/80000100/0", bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid); end
        m_delay = 1;
        repeat (8) tick();
    endtask

    task automatic test_redirect_resp();
        do_reset();
        tick();
        redirect_to(64'h8000_0200);
        n_cmp++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h8000_0200) begin
            n_fail++; $display("FAIL rr_req: got iv=%b v=%b addr=%h expected 0/1/80000200", bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr); end
        repeat (2) tick();
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'h8000_0200) begin
            n_fail++; $display("FAIL rr_inst: got v=%b pc=%h expected 1/80000200", bus.inst_valid, bus.inst_pc); end
        repeat (4) tick();
    endtask

    task automatic test_redirect_accept();
        do_reset();
        redirect_to(64'h8000_0300);
        n_cmp++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL ra_drop: got iv=%b v=%b expected 0/0", bus.inst_valid, bus.imem_req_valid); end
        tick();
        n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h8000_0300) begin
            n_fail++; $display("FAIL ra_req: got v=%b addr=%h expected 1/80000300", bus.imem_req_valid, bus.imem_req_addr); end
        repeat (6) tick();
    endtask

    task automatic test_redirect_full_pop();
        bus.inst_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL fp_full: got iv=%b v=%b expected 1/0", bus.inst_valid, bus.imem_req_valid); end
        bus.inst_ready = 1'b1;
        redirect_to(64'h8000_0400);
        n_cmp++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h8000_0400) begin
            n_fail++; $display("FAIL fp_flush: got iv=%b v=%b addr=%h expected 0/1/80000400", bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr); end
        repeat (6) tick();
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        bus.imem_req_ready = 1'b0;
        redirect_to(64'hFFFF_FFFF_FFFF_FFFE);
        n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_top: got v=%b addr=%h expected 1/fffffffffffffffc", bus.imem_req_valid, bus.imem_req_addr); end
        bus.imem_req_ready = 1'b1;
        repeat (2) tick();
        n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h0) begin
            n_fail++; $display("FAIL wrap_zero: got v=%b addr=%h expected 1/0", bus.imem_req_valid, bus.imem_req_addr); end
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_inst: got v=%b pc=%h expected 1/fffffffffffffffc", bus.inst_valid, bus.inst_pc); end
        m_delay = 3;
        tick();
        rst = 1'b1;
        bus.imem_resp_valid = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0 || bus.inst !== 32'h0 || bus.inst_pc !== 64'h0) begin
            n_fail++; $display("FAIL mid_rst: got v=%b iv=%b inst=%h pc=%h expected all 0", bus.imem_req_valid, bus.inst_valid, bus.inst, bus.inst_pc); end
        m_delay = 1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h8000_0000) begin
            n_fail++; $display("FAIL post_rst_req: got v=%b addr=%h expected 1/80000000", bus.imem_req_valid, bus.imem_req_addr); end
        repeat (6) tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.inst_ready     = ($urandom_range(0, 2) != 0);
            m_delay            = $urandom_range(1, 3);
            if ($urandom_range(0, 15) == 0) begin
                redirect_to(64'h8000_1000 + 64'($urandom_range(0, 255)) * 64'd4 + 64'($urandom_range(0, 3)));
            end else begin
                tick();
            end
        end
        bus.inst_ready     = 1'b1;
        bus.imem_req_ready = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.inst_ready      = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_resp();
        test_redirect_accept();
        test_redirect_full_pop();
        test_wrap_and_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
